sram_dp_sync: RTL and testbench
===============================

Name: sram_dp_sync

Overview:
Parametrised synchronous simple-dual-port SRAM: one write port and one read port, both clocked. It is the successor to the current asynchronous-read sram. Adds byte-enabled writes, a registered read path with configurable latency and a valid strobe, a selectable read-during-write policy, and a hardware zero-initialisation sweep after reset. It serves as the sample/coefficient buffer for the receiver datapath.

Parameters:
DATA_WIDTH, 16, word width in bits; must be a multiple of 8
ADDR_WIDTH, 8, address width; RAM_DEPTH = 1 << ADDR_WIDTH
RD_LATENCY, 1, read latency in cycles; legal values 1 or 2
RDW_MODE, 0, same-address read-during-write: 0 = read-first (old data), 1 = write-first (new merged data)
INIT_ON_RESET, 1, 1 = zero all words after reset release; 0 = no sweep

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
we  in  1  write enable
addr_w  in  ADDR_WIDTH  write address
data_w  in  DATA_WIDTH  write data
be_w  in  DATA_WIDTH/8  byte enables; bit k covers data_w[8k+7:8k]
re  in  1  read enable
addr_r  in  ADDR_WIDTH  read address
data_r  out  DATA_WIDTH  read data
rd_valid  out  1  data_r holds the result of a read issued RD_LATENCY cycles earlier
init_busy  out  1  init sweep in progress; all accesses are ignored

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values while rst_n=0: data_r=0, rd_valid=0, read pipeline cleared, init_busy=INIT_ON_RESET, sweep counter=0. The array itself is not reset.
- FSM states: IDLE and INIT. Reset places the FSM in INIT if INIT_ON_RESET=1, otherwise in IDLE.
- INIT state:
  - On each clk edge, write 0 to mem[cnt], then cnt++.
  - When the write to cnt=RAM_DEPTH-1 completes, the FSM moves to IDLE and init_busy falls on that same edge.
  - init_busy is therefore high for exactly RAM_DEPTH cycles after the first edge following rst_n release.
  - User we and re are ignored; no rd_valid is generated.
- Reset mid-sweep: the sweep aborts. It restarts from address 0 after release.
- Write (IDLE, we=1): on the rising edge, for each k with be_w[k]=1, mem[addr_w] byte k takes data_w byte k. Bytes with be_w[k]=0 are unchanged. we=1 with be_w=0 is a no-op.
- Read (IDLE, re=1): addr_r is sampled on edge N.
  - RD_LATENCY=1: data_r updates and rd_valid=1 after edge N.
  - RD_LATENCY=2: data_r updates and rd_valid=1 after edge N+1.
  - Back-to-back reads give one result per cycle.
- re=0: rd_valid deasserts at the corresponding pipeline slot. data_r holds its last value and does not return to 0.
- Read-during-write, addr_r==addr_w on the same edge:
  - RDW_MODE=0: the read returns the pre-write word.
  - RDW_MODE=1: the read returns the post-write word, with enabled bytes from data_w and other bytes from the old word.
- Different addresses on the same edge: fully independent.
- The address space is exactly RAM_DEPTH; there is no out-of-range case. The sweep counter is ADDR_WIDTH+1 bits so the terminal count is detectable.
- The 2-cycle pipeline stage also resets asynchronously. There are no combinational paths from inputs to outputs.

Test Plan:
- Reset/init, defaults: hold rst_n=0 for 3 cycles, then release -> init_busy=1 for exactly 256 cycles, then 0. Reads of addr 0, 128 and 255 return 0x0000 with rd_valid one cycle after re.
- Write/read sweep: for i=0..255, write data_w=i at addr_w=i with be_w=2'b11. Then read i=0..255 back-to-back -> data_r=i every cycle, rd_valid continuously 1.
  - Repeat with RD_LATENCY=2 -> results arrive one cycle later, otherwise identical.
- Byte enables: write 0xABCD to addr 0x10 (be=11), then 0x1234 with be=01 -> read 0xAB34. Then 0x5600 with be=10 -> read 0x5634.
- Read-during-write: addr 0x20 holds 0x1111; on the same edge write 0x2222 (be=11) and read 0x20.
  - RDW_MODE=0 -> data_r=0x1111.
  - RDW_MODE=1 -> data_r=0x2222.
  - Either mode: the next read returns 0x2222.
- Access during init: pulse we=1 (addr 5, data 0xFFFF) and re=1 while init_busy=1 -> rd_valid stays 0. Addr 5 reads 0x0000 after the sweep.
- Reset mid-sweep: assert rst_n=0 at sweep cycle 100, asynchronously and between edges -> init_busy and rd_valid are immediately at their reset values. After release, the sweep lasts a full 256 cycles. A pre-written non-zero word (written with INIT_ON_RESET=0 run first, or via a backdoor) at addr 200 reads 0.

Source files
------------

// File: rtl/sram_dp_sync.sv
// sram_dp_sync: simple dual-port synchronous SRAM with byte-enabled writes,
// registered read path (1 or 2 cycles), selectable read-during-write and zero-init sweep.
module sram_dp_sync #(
  parameter int DATA_WIDTH    = 16,
  parameter int ADDR_WIDTH    = 8,
  parameter int RD_LATENCY    = 1,
  parameter int RDW_MODE      = 0,
  parameter int INIT_ON_RESET = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    we,
  input  logic [ADDR_WIDTH-1:0]   addr_w,
  input  logic [DATA_WIDTH-1:0]   data_w,
  input  logic [DATA_WIDTH/8-1:0] be_w,
  input  logic                    re,
  input  logic [ADDR_WIDTH-1:0]   addr_r,
  output logic [DATA_WIDTH-1:0]   data_r,
  output logic                    rd_valid,
  output logic                    init_busy
);
  localparam int RAM_DEPTH = 1 << ADDR_WIDTH;
  localparam int NB = DATA_WIDTH / 8;
  typedef enum logic {IDLE, INIT} state_e;
  state_e                state_q, state_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];
  logic [DATA_WIDTH-1:0] rd_word, rd1_q;
  logic                  v1_q, last, wr_en, rd_en;
  assign init_busy = state_q == INIT;
  assign last      = cnt_q == (ADDR_WIDTH+1)'(RAM_DEPTH-1);
  assign wr_en     = we & ~init_busy;
  assign rd_en     = re & ~init_busy;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= (INIT_ON_RESET != 0) ? INIT : IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  always_comb begin
    state_d = (init_busy && last) ? IDLE : state_q;
    cnt_d   = init_busy ? (last ? '0 : cnt_q + 1'b1) : cnt_q;
  end
  // The array has no reset; only the sweep clears it.
  always_ff @(posedge clk)
    if (init_busy) mem[cnt_q[ADDR_WIDTH-1:0]] <= '0;
    else if (wr_en)
      for (int k = 0; k < NB; k++)
        if (be_w[k]) mem[addr_w][8*k +: 8] <= data_w[8*k +: 8];
  always_comb begin
    rd_word = mem[addr_r];
    for (int k = 0; k < NB; k++)
      if (RDW_MODE != 0 && wr_en && addr_w == addr_r && be_w[k]) rd_word[8*k +: 8] = data_w[8*k +: 8];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v1_q  <= 1'b0;
      rd1_q <= '0;
    end else begin
      v1_q <= rd_en;
      if (rd_en) rd1_q <= rd_word;
    end
  generate
    if (RD_LATENCY == 2) begin : g_lat2
      logic [DATA_WIDTH-1:0] rd2_q;
      logic                  v2_q;
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
          v2_q  <= 1'b0;
          rd2_q <= '0;
        end else begin
          v2_q <= v1_q;
          if (v1_q) rd2_q <= rd1_q;
        end
      assign data_r   = rd2_q;
      assign rd_valid = v2_q;
    end else begin : g_lat1
      assign data_r   = rd1_q;
      assign rd_valid = v1_q;
    end
  endgenerate
endmodule

// File: tb/tb_sram_dp_sync.sv
// tb_sram_dp_sync: directed checks of a default instance and a small
// latency-2 / write-first / no-init instance sharing clock and reset.
module tb_sram_dp_sync;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        a_we = 0, a_re = 0, b_we = 0, b_re = 0;
  logic [7:0]  a_addr_w = 0, a_addr_r = 0;
  logic [3:0]  b_addr_w = 0, b_addr_r = 0;
  logic [15:0] a_data_w = 0, b_data_w = 0, a_data_r, b_data_r;
  logic [1:0]  a_be_w = 0, b_be_w = 0;
  logic        a_rd_valid, a_init_busy, b_rd_valid, b_init_busy, seen_valid;
  int          tests = 0, fails = 0, n;
  always #5 clk = ~clk;
  sram_dp_sync u_a (
    .clk(clk), .rst_n(rst_n), .we(a_we), .addr_w(a_addr_w), .data_w(a_data_w), .be_w(a_be_w),
    .re(a_re), .addr_r(a_addr_r), .data_r(a_data_r), .rd_valid(a_rd_valid), .init_busy(a_init_busy)
  );
  sram_dp_sync #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .RD_LATENCY(2), .RDW_MODE(1), .INIT_ON_RESET(0)) u_b (
    .clk(clk), .rst_n(rst_n), .we(b_we), .addr_w(b_addr_w), .data_w(b_data_w), .be_w(b_be_w),
    .re(b_re), .addr_r(b_addr_r), .data_r(b_data_r), .rd_valid(b_rd_valid), .init_busy(b_init_busy)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic wr_a(input logic [7:0] a, input logic [15:0] d, input logic [1:0] be);
    a_we = 1; a_addr_w = a; a_data_w = d; a_be_w = be;
    tick;
    a_we = 0;
  endtask
  task automatic rd_a(input logic [7:0] a);
    a_re = 1; a_addr_r = a;
    tick;
    a_re = 0;
  endtask
  task automatic wr_b(input logic [3:0] a, input logic [15:0] d, input logic [1:0] be);
    b_we = 1; b_addr_w = a; b_data_w = d; b_be_w = be;
    tick;
    b_we = 0;
  endtask
  task automatic rd_b(input logic [3:0] a);
    b_re = 1; b_addr_r = a;
    tick;
    b_re = 0;
    tick;
  endtask
  task automatic count_init;
    n = 0;
    while (a_init_busy && n < 1000) begin
      tick;
      seen_valid |= a_rd_valid;
      n++;
    end
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_a_busy", a_init_busy, 1);
    chk("rst_a_valid", a_rd_valid, 0);
    chk("rst_a_data", a_data_r, 0);
    chk("rst_b_busy", b_init_busy, 0);
    chk("rst_b_valid", b_rd_valid, 0);
    chk("rst_b_data", b_data_r, 0);
    rst_n = 1;
    // Accesses attempted during the sweep must be ignored.
    a_we = 1; a_addr_w = 5; a_data_w = 16'hFFFF; a_be_w = 2'b11; a_re = 1; a_addr_r = 5;
    seen_valid = 0;
    n = 0;
    tick;
    n++;
    seen_valid |= a_rd_valid;
    a_we = 0; a_re = 0;
    while (a_init_busy && n < 1000) begin
      tick;
      seen_valid |= a_rd_valid;
      n++;
    end
    chk("init_len", n, 256);
    chk("init_no_valid", seen_valid, 0);
    rd_a(0);   chk("init_rd0", a_data_r, 0); chk("init_rd0_v", a_rd_valid, 1);
    rd_a(128); chk("init_rd128", a_data_r, 0);
    rd_a(255); chk("init_rd255", a_data_r, 0);
    a_data_r_poison: begin
      wr_a(8'd3, 16'h0F0F, 2'b11);
      rd_a(3); chk("poison_rd3", a_data_r, 16'h0F0F);
    end
    rd_a(5);   chk("init_rd5", a_data_r, 0); chk("init_rd5_v", a_rd_valid, 1);
    tick;      chk("idle_valid", a_rd_valid, 0); chk("idle_hold", a_data_r, 0);
    for (int i = 0; i < 256; i++) wr_a(8'(i), 16'(i), 2'b11);
    seen_valid = 1;
    n = 0;
    for (int i = 0; i < 256; i++) begin
      a_re = 1; a_addr_r = 8'(i);
      tick;
      seen_valid &= a_rd_valid;
      if (a_data_r !== 16'(i)) n++;
    end
    a_re = 0;
    chk("sweep_errs", n, 0);
    chk("sweep_valid", seen_valid, 1);
    rd_a(8'd77); chk("sweep_rd77", a_data_r, 16'h004D);
    wr_a(8'h10, 16'hABCD, 2'b11);
    wr_a(8'h10, 16'h1234, 2'b01);
    rd_a(8'h10); chk("be_lo", a_data_r, 16'hAB34);
    wr_a(8'h10, 16'h5600, 2'b10);
    rd_a(8'h10); chk("be_hi", a_data_r, 16'h5634);
    wr_a(8'h10, 16'hFFFF, 2'b00);
    rd_a(8'h10); chk("be_none", a_data_r, 16'h5634);
    wr_a(8'h20, 16'h1111, 2'b11);
    a_we = 1; a_addr_w = 8'h20; a_data_w = 16'h2222; a_be_w = 2'b11; a_re = 1; a_addr_r = 8'h20;
    tick;
    a_we = 0;
    chk("rdw_old", a_data_r, 16'h1111);
    tick;
    chk("rdw_next", a_data_r, 16'h2222);
    a_re = 0;
    tick;
    chk("re0_valid", a_rd_valid, 0);
    chk("re0_hold", a_data_r, 16'h2222);
    a_we = 1; a_addr_w = 8'h30; a_data_w = 16'h3333; a_be_w = 2'b11; a_re = 1; a_addr_r = 8'h10;
    tick;
    a_we = 0; a_re = 0;
    chk("indep_rd", a_data_r, 16'h5634);
    rd_a(8'h30); chk("indep_wr", a_data_r, 16'h3333);
    chk("b_idle_busy", b_init_busy, 0);
    for (int i = 0; i < 16; i++) wr_b(4'(i), 16'hA000 | 16'(i), 2'b11);
    n = 0;
    for (int i = 0; i <= 16; i++) begin
      b_re = (i < 16); b_addr_r = 4'(i);
      tick;
      if (i == 0) chk("b_lat2_first", b_rd_valid, 0);
      else if (b_data_r !== (16'hA000 | 16'(i - 1)) || b_rd_valid !== 1'b1) n++;
    end
    chk("b_sweep_errs", n, 0);
    tick;
    chk("b_re0_valid", b_rd_valid, 0);
    chk("b_re0_hold", b_data_r, 16'hA00F);
    b_re = 1; b_addr_r = 4'd7;
    tick;
    b_re = 0;
    chk("b_lat2_mid", b_data_r, 16'hA00F);
    tick;
    chk("b_lat2_data", b_data_r, 16'hA007);
    wr_b(4'd5, 16'hABCD, 2'b11);
    wr_b(4'd5, 16'h1234, 2'b01);
    rd_b(4'd5); chk("b_be_lo", b_data_r, 16'hAB34);
    wr_b(4'd2, 16'h1111, 2'b11);
    b_we = 1; b_addr_w = 4'd2; b_data_w = 16'h2222; b_be_w = 2'b01; b_re = 1; b_addr_r = 4'd2;
    tick;
    b_we = 0; b_re = 0;
    tick;
    chk("b_rdw_new", b_data_r, 16'h1122);
    chk("b_rdw_valid", b_rd_valid, 1);
    rd_b(4'd2); chk("b_rdw_next", b_data_r, 16'h1122);
    a_re = 1; a_addr_r = 8'd200; b_re = 1; b_addr_r = 4'd3;
    tick;
    tick;
    chk("pre_rst_a", a_data_r, 16'h00C8);
    chk("pre_rst_a_v", a_rd_valid, 1);
    chk("pre_rst_b", b_data_r, 16'hA003);
    chk("pre_rst_b_v", b_rd_valid, 1);
    #2 rst_n = 0;
    #1;
    a_re = 0; b_re = 0;
    chk("arst_a_data", a_data_r, 0);
    chk("arst_a_valid", a_rd_valid, 0);
    chk("arst_a_busy", a_init_busy, 1);
    chk("arst_b_data", b_data_r, 0);
    chk("arst_b_valid", b_rd_valid, 0);
    repeat (3) tick;
    rst_n = 1;
    repeat (100) tick;
    chk("mid_busy", a_init_busy, 1);
    #2 rst_n = 0;
    #1;
    chk("mid_rst_busy", a_init_busy, 1);
    chk("mid_rst_valid", a_rd_valid, 0);
    repeat (3) tick;
    rst_n = 1;
    seen_valid = 0;
    count_init;
    chk("restart_len", n, 256);
    rd_a(8'd200); chk("restart_rd200", a_data_r, 0);
    rd_a(8'd30);  chk("restart_rd30", a_data_r, 0);
    rd_b(4'd2);   chk("b_no_init_keep", b_data_r, 16'h1122);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
